key_debounce_mc: RTL
====================

KEY_DEBOUNCE_MC -- requirements
Module: key_debounce_mc

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of independent key channels, range 1..32.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 means a key reads as pressed when the pin is 0; 0 means pressed when the pin is 1.
REQ-003 Parameter DEB_CYCLES, default 1_000_000 (20 ms at 50 MHz): stable-level qualification time in clk cycles, minimum 2.
REQ-004 Parameter LONG_CYCLES, default 50_000_000 (1 s): continuous hold time before a long-press event, greater than DEB_CYCLES.
REQ-005 Parameter REPEAT_CYCLES, default 10_000_000 (200 ms): auto-repeat period after a long press, minimum 2.
REQ-006 Parameter REPEAT_EN, default 1: 1 enables auto-repeat; 0 suppresses all repeat_pulse events.
REQ-007 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Port key_in, input, NUM_KEYS bits: raw asynchronous key pins.
REQ-010 Port key_state, output, NUM_KEYS bits: debounced level, 1 = pressed, polarity already normalised.
REQ-011 Port press_pulse, output, NUM_KEYS bits: one-cycle pulse on a debounced press.
REQ-012 Port release_pulse, output, NUM_KEYS bits: one-cycle pulse on a debounced release.
REQ-013 Port long_pulse, output, NUM_KEYS bits: one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-014 Port repeat_pulse, output, NUM_KEYS bits: one-cycle pulse every REPEAT_CYCLES after long_pulse.
REQ-015 Port any_pressed, output, 1 bit: registered OR of key_state.
REQ-016 All outputs SHALL be registered.

Function
REQ-017 Each channel SHALL pass key_in through a two-flop synchroniser, then apply the ACTIVE_LOW inversion.
REQ-018 Each channel SHALL have a debounce counter of width $clog2(DEB_CYCLES+1), reloaded to 0 whenever the synchronised level equals key_state.
REQ-019 While the synchronised level differs from key_state, the debounce counter SHALL increment each cycle.
REQ-020 When the synchronised level has differed from key_state for DEB_CYCLES consecutive cycles, key_state SHALL toggle on the next edge and the counter SHALL clear.
REQ-021 Any glitch shorter than DEB_CYCLES SHALL produce no change on any output.
REQ-022 Latency from a clean key_in edge to the key_state change SHALL be exactly DEB_CYCLES+2 cycles.
REQ-023 press_pulse SHALL assert in the same cycle key_state rises; release_pulse SHALL assert in the same cycle key_state falls; each pulse SHALL be exactly one cycle wide.
REQ-024 Each channel SHALL run a hold FSM with states IDLE, HELD and LONG.
REQ-025 FSM transitions: IDLE->HELD on key_state rising; HELD->LONG when the hold counter reaches LONG_CYCLES, asserting long_pulse for one cycle; HELD or LONG->IDLE on key_state falling.
REQ-026 The hold counter (width $clog2(LONG_CYCLES+1)) SHALL clear on entry to HELD, increment in HELD, and saturate at LONG_CYCLES without wrapping.
REQ-027 In LONG with REPEAT_EN=1, a repeat counter SHALL assert repeat_pulse for one cycle every REPEAT_CYCLES cycles, the first pulse coming REPEAT_CYCLES cycles after long_pulse; the counter SHALL wrap to 0 after each pulse.
REQ-028 A release in the same cycle a long or repeat event would fire SHALL suppress that event; only release_pulse SHALL assert.
REQ-029 Channels SHALL be fully independent; simultaneous events on multiple channels SHALL all be reported in the same cycle.
REQ-030 any_pressed SHALL lag key_state by one cycle.

Reset
REQ-031 On rst=1 at a clk edge, key_state, all pulse outputs, any_pressed, all counters and all FSM states (IDLE) SHALL be 0.
REQ-032 The synchroniser flops SHALL reset to the released pin level, so a key held through reset produces press_pulse DEB_CYCLES+2 cycles after rst is deasserted.
REQ-033 Reset asserted mid-debounce or mid-hold SHALL abort the operation; no pulse SHALL fire during or because of reset.

Verification (NUM_KEYS=4, ACTIVE_LOW=1, DEB_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=8)
REQ-034 key_in[0] 1->0 held -> key_state[0]=1 and press_pulse[0]=1 for one cycle, exactly 10 cycles after the edge; any_pressed=1 one cycle later.
REQ-035 key_in[1] low for 7 cycles then high again, repeated 5 times -> all outputs stay 0.
REQ-036 key_in[2] held low for 80 cycles -> long_pulse[2] 32 cycles after press_pulse[2], then repeat_pulse[2] at +8, +16, +24..., then release_pulse[2] 10 cycles after the pin returns high.
REQ-037 Same as REQ-036 with REPEAT_EN=0 -> long_pulse[2] once; no repeat_pulse.
REQ-038 key_in[0] and key_in[3] fall in the same cycle -> press_pulse=4'b1001 in a single cycle.
REQ-039 rst pulsed while key_in[1] is held low mid-debounce -> all outputs 0 during reset; press_pulse[1] exactly 10 cycles after rst falls.

Source files
------------

// File: rtl/key_debounce_mc.sv
// ---------------------------------------------------------------------------
// key_debounce_mc
// Multi-channel key debouncer. Each channel has a synchroniser, a debounce
// qualifier and a hold FSM that produces press, release, long-press and
// auto-repeat events.
//
// Ports
//   clk           : single rising-edge clock
//   rst           : synchronous active-high reset
//   key_in        : raw asynchronous key pins, one bit per channel
//   key_state     : debounced level, 1 = pressed (polarity normalised)
//   press_pulse   : one-cycle pulse when key_state rises
//   release_pulse : one-cycle pulse when key_state falls
//   long_pulse    : one-cycle pulse when a hold reaches LONG_CYCLES
//   repeat_pulse  : one-cycle pulse every REPEAT_CYCLES after long_pulse
//   any_pressed   : registered OR of key_state (one cycle behind it)
// ---------------------------------------------------------------------------
module key_debounce_mc #(
  parameter int NUM_KEYS      = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                any_pressed
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  // Compare against N-1: the counter value seen at the edge that completes
  // the N-th consecutive cycle of the condition.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  // Pin level of a released key; synchroniser reset value.
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  logic [NUM_KEYS-1:0] w_state;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] w_long;
  logic [NUM_KEYS-1:0] w_repeat;
  logic                r_any;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic          r_s1;
    logic          r_s2;
    logic [DW-1:0] r_dcnt;
    logic          r_state;
    logic          r_press;
    logic          r_release;
    logic [1:0]    r_fsm;
    logic [HW-1:0] r_hcnt;
    logic [RW-1:0] r_rcnt;
    logic          r_long;
    logic          r_repeat;

    logic w_lvl;
    logic w_diff;
    logic w_toggle;
    logic w_rise;
    logic w_fall;
    logic w_long_hit;
    logic w_rep_hit;

    assign w_lvl    = (ACTIVE_LOW != 0) ? ~r_s2 : r_s2;
    assign w_diff   = w_lvl ^ r_state;
    assign w_toggle = w_diff & (r_dcnt == DEB_LAST);
    assign w_rise   = w_toggle & ~r_state;
    assign w_fall   = w_toggle & r_state;
    // A release landing on the same edge as a long/repeat event wins.
    assign w_long_hit = (r_fsm == ST_HELD) & (r_hcnt == HOLD_LAST) & ~w_fall;
    assign w_rep_hit  = (REPEAT_EN != 0) & (r_fsm == ST_LONG) &
                        (r_rcnt == REP_LAST) & ~w_fall;

    // Synchroniser, debounce counter, debounced level and edge pulses.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1      <= IDLE_PIN;
        r_s2      <= IDLE_PIN;
        r_dcnt    <= '0;
        r_state   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_s1      <= key_in[g];
        r_s2      <= r_s1;
        r_press   <= w_rise;
        r_release <= w_fall;
        if (w_toggle) begin
          r_state <= ~r_state;
          r_dcnt  <= '0;
        end else if (w_diff) begin
          r_dcnt <= r_dcnt + 1'b1;
        end else begin
          r_dcnt <= '0;
        end
      end
    end

    // Hold FSM with saturating hold counter and wrapping repeat counter.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_fsm    <= ST_IDLE;
        r_hcnt   <= '0;
        r_rcnt   <= '0;
        r_long   <= 1'b0;
        r_repeat <= 1'b0;
      end else begin
        r_long   <= w_long_hit;
        r_repeat <= w_rep_hit;
        case (r_fsm)
          ST_IDLE: begin
            // Counters sit at zero here, so HELD is always entered cleared.
            r_hcnt <= '0;
            r_rcnt <= '0;
            if (w_rise) begin
              r_fsm <= ST_HELD;
            end else begin
              r_fsm <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (w_fall) begin
              r_fsm  <= ST_IDLE;
              r_hcnt <= '0;
            end else begin
              if (r_hcnt != HOLD_MAX) begin
                r_hcnt <= r_hcnt + 1'b1;
              end else begin
                r_hcnt <= r_hcnt;
              end
              if (w_long_hit) begin
                r_fsm  <= ST_LONG;
                r_rcnt <= '0;
              end else begin
                r_fsm <= ST_HELD;
              end
            end
          end
          ST_LONG: begin
            if (w_fall) begin
              r_fsm  <= ST_IDLE;
              r_hcnt <= '0;
              r_rcnt <= '0;
            end else begin
              r_fsm <= ST_LONG;
              if (r_rcnt == REP_LAST) begin
                r_rcnt <= '0;
              end else begin
                r_rcnt <= r_rcnt + 1'b1;
              end
            end
          end
          default: begin
            r_fsm  <= ST_IDLE;
            r_hcnt <= '0;
            r_rcnt <= '0;
          end
        endcase
      end
    end

    assign w_state[g]   = r_state;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
    assign w_long[g]    = r_long;
    assign w_repeat[g]  = r_repeat;
  end

  // any_pressed follows the registered key_state, one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_state;
    end
  end

  assign key_state     = w_state;
  assign press_pulse   = w_press;
  assign release_pulse = w_release;
  assign long_pulse    = w_long;
  assign repeat_pulse  = w_repeat;
  assign any_pressed   = r_any;

endmodule
